// File: rtl/dr_pkg.sv
// Shared definitions for data_assembly_register: operation encodings and
// the fill-count width helper.
package dr_pkg;

    typedef enum logic [1:0] {
        DR_LOAD_ZX = 2'b00,
        DR_LOAD_SX = 2'b01,
        DR_SHL     = 2'b10,
        DR_SHR     = 2'b11
    } dr_funsel_e;

    // Count must represent 0..n inclusive, hence n+1 states.
    function automatic int dr_count_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : dr_pkg

// File: rtl/dr_fill_counter.sv
// Saturating 0..N slice counter: load-to-1, increment, hold.
// Also flags when an increment is accepted while already full.
module dr_fill_counter #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          ovf_set
);

    logic [CW-1:0] count_next;

    // Full is decoded from the registered count only, so it cannot glitch
    // on input changes.
    assign full    = (count == CW'(N));
    assign ovf_set = inc & full;

    // NOTE: always_comb gives every output a default first so no latch is inferred.
    always_comb begin
        count_next = count;
        if (load)
            count_next = CW'(1);
        else if (inc && !full)
            count_next = count + CW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else
            count <= count_next;
    end

endmodule : dr_fill_counter

// File: rtl/data_assembly_register.sv
// Assembles an OUT_W-bit word from IN_W-bit slices (load ZX/SX, shift L/R).
// Optional macro DR_PARITY_EN adds a registered even-parity output Parity.
module data_assembly_register
    import dr_pkg::*;
#(
    parameter  int IN_W  = 8,
    parameter  int OUT_W = 32,
    localparam int N     = OUT_W / IN_W,
    localparam int CW    = dr_count_w(N)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [IN_W-1:0]  I,
    input  logic             E,
    input  logic [1:0]       FunSel,
    output logic [OUT_W-1:0] DROut,
    output logic [CW-1:0]    Count,
    output logic             Full,
`ifdef DR_PARITY_EN
    output logic             Parity,
`endif
    output logic             Overflow
);

    dr_funsel_e       fun;
    logic [OUT_W-1:0] dr_next;
    logic             is_load;
    logic             is_shift;
    logic             ovf_set;

    assign fun      = dr_funsel_e'(FunSel);
    assign is_load  = E & ~FunSel[1];
    assign is_shift = E &  FunSel[1];

    always_comb begin
        dr_next = DROut;
        unique case (fun)
            DR_LOAD_ZX: dr_next = {{(OUT_W-IN_W){1'b0}}, I};
            DR_LOAD_SX: dr_next = {{(OUT_W-IN_W){I[IN_W-1]}}, I};
            DR_SHL:     dr_next = {DROut[OUT_W-IN_W-1:0], I};
            DR_SHR:     dr_next = {I, DROut[OUT_W-1:IN_W]};
            default:    dr_next = DROut;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            DROut <= '0;
        else if (E)
            DROut <= dr_next;
    end

    dr_fill_counter #(
        .N  (N),
        .CW (CW)
    ) u_fill_counter (
        .clk     (Clock),
        .rst_n   (Reset),
        .load    (is_load),
        .inc     (is_shift),
        .count   (Count),
        .full    (Full),
        .ovf_set (ovf_set)
    );

    // Overflow is sticky across shifts; only a load or reset restarts it.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            Overflow <= 1'b0;
        else if (is_load)
            Overflow <= 1'b0;
        else if (ovf_set)
            Overflow <= 1'b1;
    end

`ifdef DR_PARITY_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            Parity <= 1'b0;
        else if (E)
            Parity <= ^dr_next;
    end
`endif

endmodule : data_assembly_register

// File: tb/tb_data_assembly_register.sv
// Self-checking bench for data_assembly_register (IN_W=8, OUT_W=32) with a
// word-level arithmetic model and a per-cycle compare process.
module tb_data_assembly_register;

    localparam int IN_W  = 8;
    localparam int OUT_W = 32;
    localparam int N     = 4;
    localparam int CW    = 3;

    logic             Clock;
    logic             Reset;
    logic [IN_W-1:0]  I;
    logic             E;
    logic [1:0]       FunSel;
    logic [OUT_W-1:0] DROut;
    logic [CW-1:0]    Count;
    logic             Full;
    logic             Overflow;
`ifdef DR_PARITY_EN
    logic             Parity;
`endif

    data_assembly_register #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .I        (I),
        .E        (E),
        .FunSel   (FunSel),
        .DROut    (DROut),
        .Count    (Count),
        .Full     (Full),
`ifdef DR_PARITY_EN
        .Parity   (Parity),
`endif
        .Overflow (Overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_dr;
    int          m_cnt;
    bit          m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dr  = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // Word-level model: loads replace the word, shifts multiply/divide by 256.
    task automatic model_step(input logic e, input logic [1:0] fs, input logic [7:0] d);
        if (!e) return;
        case (fs)
            2'b00: begin m_dr = 32'(d);                     m_cnt = 1; m_ovf = 1'b0; end
            2'b01: begin m_dr = 32'(signed'(d));            m_cnt = 1; m_ovf = 1'b0; end
            2'b10: m_dr = (m_dr << 8) | 32'(d);
            default: m_dr = (m_dr >> 8) | (32'(d) << 24);
        endcase
        if (fs[1]) begin
            if (m_cnt == N) m_ovf = 1'b1;
            m_cnt = (m_cnt < N) ? m_cnt + 1 : N;
        end
    endtask

    task automatic step(input logic e, input logic [1:0] fs, input logic [7:0] d);
        E = e; FunSel = fs; I = d;
        @(posedge Clock);
        model_step(e, fs, d);
        #1;
    endtask

    // Asynchronous reset pulse away from any clock edge.
    task automatic async_reset();
        Reset = 1'b0;
        model_reset();
        #1;
        check("rst_drout", DROut, 32'h0);
        check("rst_count", 32'(Count), 32'h0);
        check("rst_full", 32'(Full), 32'h0);
        check("rst_ovf", 32'(Overflow), 32'h0);
`ifdef DR_PARITY_EN
        check("rst_parity", 32'(Parity), 32'h0);
`endif
        #1 Reset = 1'b1;
    endtask

    always @(negedge Clock) begin
        if (chk_en) begin
            check("cyc_drout", DROut, m_dr);
            check("cyc_count", 32'(Count), 32'(m_cnt));
            check("cyc_full", 32'(Full), 32'(m_cnt == N));
            check("cyc_ovf", 32'(Overflow), 32'(m_ovf));
`ifdef DR_PARITY_EN
            check("cyc_parity", 32'(Parity), 32'(^m_dr));
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b0; E = 1'b0; FunSel = 2'b00; I = '0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b1;
        check("init_drout", DROut, 32'h0);
        check("init_count", 32'(Count), 32'h0);
        chk_en = 1'b1;

        // Reset in the middle of an assembly.
        step(1'b1, 2'b10, 8'h34);
        step(1'b1, 2'b10, 8'h56);
        step(1'b1, 2'b10, 8'h78);
        check("mid_drout", DROut, 32'h00345678);
        check("mid_count", 32'(Count), 32'd3);
        async_reset();

        // Hold with E=0.
        step(1'b1, 2'b00, 8'h02);
        step(1'b1, 2'b10, 8'h20);
        step(1'b1, 2'b10, 8'h18);
        step(1'b0, 2'b00, 8'h25);
        check("hold_drout", DROut, 32'h00022018);
        check("hold_count", 32'(Count), 32'd3);

        // Loads.
        step(1'b1, 2'b00, 8'hA5);
        check("ldzx_drout", DROut, 32'h000000A5);
        check("ldzx_count", 32'(Count), 32'd1);
        step(1'b1, 2'b01, 8'hA5);
        check("ldsx_neg", DROut, 32'hFFFFFFA5);
        step(1'b1, 2'b01, 8'h25);
        check("ldsx_pos", DROut, 32'h00000025);

        // Left assembly from reset, then overflow.
        async_reset();
        step(1'b1, 2'b10, 8'h12);
        step(1'b1, 2'b10, 8'h34);
        step(1'b1, 2'b10, 8'h56);
        step(1'b1, 2'b10, 8'h78);
        check("shl_drout", DROut, 32'h12345678);
        check("shl_count", 32'(Count), 32'd4);
        check("shl_full", 32'(Full), 32'd1);
        check("shl_ovf0", 32'(Overflow), 32'd0);
        step(1'b1, 2'b10, 8'h9A);
        check("shl5_drout", DROut, 32'h3456789A);
        check("shl5_count", 32'(Count), 32'd4);
        check("shl5_ovf", 32'(Overflow), 32'd1);

        // Right assembly then reload.
        async_reset();
        step(1'b1, 2'b11, 8'h78);
        step(1'b1, 2'b11, 8'h56);
        step(1'b1, 2'b11, 8'h34);
        step(1'b1, 2'b11, 8'h12);
        check("shr_drout", DROut, 32'h12345678);
        check("shr_full", 32'(Full), 32'd1);
        step(1'b1, 2'b00, 8'h01);
        check("reld_drout", DROut, 32'h00000001);
        check("reld_count", 32'(Count), 32'd1);
        check("reld_ovf", 32'(Overflow), 32'd0);

`ifdef DR_PARITY_EN
        step(1'b1, 2'b00, 8'h07);
        check("par_ld", 32'(Parity), 32'd1);
        step(1'b1, 2'b10, 8'h01);
        check("par_shl_drout", DROut, 32'h00000701);
        check("par_shl", 32'(Parity), 32'd0);
`endif

        // Randomised traffic, shift-heavy so Full and Overflow are exercised.
        for (int k = 0; k < 600; k++) begin
            logic [1:0] fs;
            if ($urandom_range(0, 59) == 0) begin
                async_reset();
            end else begin
                fs = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1))
                                                 : 2'($urandom_range(2, 3));
                step(($urandom_range(0, 4) != 0), fs, 8'($urandom));
            end
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_data_assembly_register
